dice_roller: RTL

Upstream stage of the dice game: turns the raw roll push-button into a debounced roll gesture and produces two die values (1–6) plus their sum. These values are what the game FSM and display path consume. While the button is held, two mod-6 counters spin. When it is released they are latched and a one-cycle `roll_valid` pulse is issued, so downstream logic sees exactly one new roll per press.

---
 rtl/dice_pkg.sv | 18 +
 rtl/button_debouncer.sv | 55 +++++
 rtl/dice_roller.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dice_pkg.sv
// dice_pkg: shared types and constants for the dice roller.
//   state_e   : roller FSM states (idle, spinning, latching a result)
//   DIE_MIN   : lowest face value
//   DIE_MAX   : highest face value
//   LFSR_TAPS : Galois feedback mask for the optional 16-bit LFSR
package dice_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRolling,
      StLatch
   } state_e;

   localparam logic [2:0]  DIE_MIN   = 3'd1;
   localparam logic [2:0]  DIE_MAX   = 3'd6;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: two-flop synchronizer followed by a stable-level debounce counter.
// The debounced level only changes after the synchronized input has differed from it for
// DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : synchronous active-low reset
//   btn_i   : raw asynchronous button level
//   level_o : debounced button level
module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic level_o
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

   logic            sync1_q, sync2_q;
   logic            level_q, level_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [CntW-1:0] cnt_inc;

   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      cnt_inc = cnt_q + CntW'(1);
      if (sync2_q != level_q) begin
         if (cnt_inc == CntW'(DEBOUNCE_CYCLES)) begin
            // Level accepted: toggle and restart counting from zero.
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_inc;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/dice_roller.sv
// dice_roller: debounced roll button drives two spinning die counters; on release the
// counters are latched into die1/die2/sum with a one-cycle roll_valid pulse.
// Optional feature macro: DICE_LFSR_EN adds a free-running 16-bit Galois LFSR whose lsb
// makes the first die advance by 1 or 2 per spinning cycle.
// Ports:
//   clock      : clock, rising edge
//   reset      : synchronous active-low reset
//   roll       : raw bouncing roll button, active-high
//   die1, die2 : latched die values 1..6 (0 until the first roll)
//   sum        : die1 + die2 (0 until the first roll)
//   roll_valid : one-cycle pulse when new values appear
//   rolling    : high while the dice spin
module dice_roller
   import dice_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       roll,
   output logic [2:0] die1,
   output logic [2:0] die2,
   output logic [3:0] sum,
   output logic       roll_valid,
   output logic       rolling
);

   logic       level;
   state_e     state_q, state_d;
   logic [2:0] c1_q, c1_d, c2_q, c2_d;
   logic [2:0] die1_q, die1_d, die2_q, die2_d;
   logic [3:0] sum_q, sum_d;
   logic [1:0] step;
   logic [3:0] c1_sum, c2_sum;
   logic       c1_wrap, c2_wrap;
   logic [2:0] c1_spin, c2_spin;

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk_i  (clock),
      .rst_ni (reset),
      .btn_i  (roll),
      .level_o(level)
   );

`ifdef DICE_LFSR_EN
   localparam logic [15:0] SeedEff = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         lfsr_q <= SeedEff;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign step = lfsr_q[0] ? 2'd2 : 2'd1;
`else
   // Seed has no effect without the LFSR; this empty block only keeps it elaborated.
   if (LFSR_SEED == 16'h0000) begin : g_seed_unused
   end

   assign step = 2'd1;
`endif

   // Spin values: wrap past DIE_MAX back into DIE_MIN..DIE_MAX; c2 ticks on a c1 wrap.
   always_comb begin
      c1_sum  = {1'b0, c1_q} + {2'b00, step};
      c1_wrap = (c1_sum > {1'b0, DIE_MAX});
      c1_spin = c1_wrap ? 3'(c1_sum - {1'b0, DIE_MAX}) : c1_sum[2:0];
      c2_sum  = {1'b0, c2_q} + {3'b000, c1_wrap};
      c2_wrap = (c2_sum > {1'b0, DIE_MAX});
      c2_spin = c2_wrap ? DIE_MIN : c2_sum[2:0];
   end

   always_comb begin
      state_d = state_q;
      c1_d    = c1_q;
      c2_d    = c2_q;
      die1_d  = die1_q;
      die2_d  = die2_q;
      sum_d   = sum_q;
      case (state_q)
         StIdle: begin
            // Level can only be high in idle after a fresh debounced rise.
            if (level) begin
               state_d = StRolling;
            end
         end
         StRolling: begin
            c1_d = c1_spin;
            c2_d = c2_spin;
            if (!level) begin
               state_d = StLatch;
               // Load outputs now so they change in the same cycle roll_valid pulses.
               die1_d  = c1_spin;
               die2_d  = c2_spin;
               sum_d   = {1'b0, c1_spin} + {1'b0, c2_spin};
            end
         end
         StLatch: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= StIdle;
         c1_q    <= DIE_MIN;
         c2_q    <= DIE_MIN;
         die1_q  <= 3'd0;
         die2_q  <= 3'd0;
         sum_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         c1_q    <= c1_d;
         c2_q    <= c2_d;
         die1_q  <= die1_d;
         die2_q  <= die2_d;
         sum_q   <= sum_d;
      end
   end

   assign die1       = die1_q;
   assign die2       = die2_q;
   assign sum        = sum_q;
   assign roll_valid = (state_q == StLatch);
   assign rolling    = (state_q == StRolling);

endmodule
